// File: rtl/mem_arbiter_n_if.sv
// Bundle of the signals between the L1 requesters, the arbiter and the L2 port.
//   slave  : arbiter view (takes channel requests and the L2 response, drives L2 strobes and grant info)
//   master : environment view (drives channel requests and the L2 response)
interface mem_arbiter_n_if #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned BURST_W = 128
);
    localparam int unsigned ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]         req_read;
    logic [NUM_CH-1:0]         req_write;
    logic [NUM_CH*ADDR_W-1:0]  req_address;
    logic [NUM_CH*BURST_W-1:0] req_wdata;
    logic [NUM_CH-1:0]         req_resp;
    logic [BURST_W-1:0]        req_rdata;
    logic [ADDR_W-1:0]         l2_address;
    logic                      l2_read;
    logic                      l2_write;
    logic [BURST_W-1:0]        l2_wdata;
    logic                      l2_resp;
    logic [BURST_W-1:0]        l2_rdata;
    logic                      grant_valid;
    logic [ID_W-1:0]           grant_id;

    modport slave (
        input  req_read, req_write, req_address, req_wdata, l2_resp, l2_rdata,
        output req_resp, req_rdata, l2_address, l2_read, l2_write, l2_wdata,
               grant_valid, grant_id
    );

    modport master (
        output req_read, req_write, req_address, req_wdata, l2_resp, l2_rdata,
        input  req_resp, req_rdata, l2_address, l2_read, l2_write, l2_wdata,
               grant_valid, grant_id
    );
endinterface

// File: rtl/mem_arbiter_n.sv
// N-channel arbiter between L1 requesters and the shared L2 port.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : channel requests/responses, registered L2 strobes, grant visibility
module mem_arbiter_n #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned BURST_W = 128,
    parameter int unsigned RR_MODE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_arbiter_n_if.slave   bus
);
    localparam int unsigned ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               r_state, w_state_nxt;
    logic [ID_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
    logic [ID_W-1:0]      r_grant_id, w_grant_id_nxt;
    logic                 r_grant_valid, w_grant_valid_nxt;
    logic                 r_l2_read, w_l2_read_nxt;
    logic                 r_l2_write, w_l2_write_nxt;
    logic [ADDR_W-1:0]    r_l2_address, w_l2_address_nxt;
    logic [BURST_W-1:0]   r_l2_wdata, w_l2_wdata_nxt;

    logic [NUM_CH-1:0]    w_req;
    logic [ID_W-1:0]      w_base;
    logic                 w_found;
    logic [ID_W-1:0]      w_winner;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [BURST_W-1:0]   w_sel_wdata;
    logic                 w_sel_rd, w_sel_wr;
    logic [NUM_CH-1:0]    w_req_resp;
    logic [BURST_W-1:0]   w_req_rdata;

    assign w_req = bus.req_read | bus.req_write;

    // Winner search: first requester at or after the base, then wrap to the low indices.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_base   = (RR_MODE != 0) ? r_rr_ptr : '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!w_found && w_req[i] && (ID_W'(i) >= w_base)) begin
                w_found  = 1'b1;
                w_winner = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!w_found && w_req[i]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(i);
            end
        end
    end

    // Payload mux for the selected channel.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_rd    = 1'b0;
        w_sel_wr    = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_addr  = bus.req_address[i*ADDR_W +: ADDR_W];
                w_sel_wdata = bus.req_wdata[i*BURST_W +: BURST_W];
                w_sel_rd    = bus.req_read[i];
                w_sel_wr    = bus.req_write[i];
            end
        end
    end

    // Next-state and next-register values; completion response is combinational.
    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_grant_id_nxt    = r_grant_id;
        w_grant_valid_nxt = r_grant_valid;
        w_l2_read_nxt     = r_l2_read;
        w_l2_write_nxt    = r_l2_write;
        w_l2_address_nxt  = r_l2_address;
        w_l2_wdata_nxt    = r_l2_wdata;
        w_req_resp        = '0;
        w_req_rdata       = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt       = BUSY;
                    w_grant_id_nxt    = w_winner;
                    w_grant_valid_nxt = 1'b1;
                    w_l2_address_nxt  = w_sel_addr;
                    w_l2_wdata_nxt    = w_sel_wdata;
                    // Write takes precedence when both request levels are set.
                    w_l2_write_nxt    = w_sel_wr;
                    w_l2_read_nxt     = w_sel_rd & ~w_sel_wr;
                end
            end
            BUSY: begin
                w_req_rdata = bus.l2_rdata;
                if (bus.l2_resp) begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (r_grant_id == ID_W'(i)) w_req_resp[i] = 1'b1;
                    end
                    w_state_nxt       = IDLE;
                    w_grant_valid_nxt = 1'b0;
                    w_l2_read_nxt     = 1'b0;
                    w_l2_write_nxt    = 1'b0;
                    w_rr_ptr_nxt      = (r_grant_id == ID_W'(NUM_CH-1)) ? '0
                                                                         : r_grant_id + ID_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and L2-side registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_l2_read     <= 1'b0;
            r_l2_write    <= 1'b0;
            r_l2_address  <= '0;
            r_l2_wdata    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_l2_read     <= w_l2_read_nxt;
            r_l2_write    <= w_l2_write_nxt;
            r_l2_address  <= w_l2_address_nxt;
            r_l2_wdata    <= w_l2_wdata_nxt;
        end
    end

    assign bus.req_resp    = w_req_resp;
    assign bus.req_rdata   = w_req_rdata;
    assign bus.l2_address  = r_l2_address;
    assign bus.l2_read     = r_l2_read;
    assign bus.l2_write    = r_l2_write;
    assign bus.l2_wdata    = r_l2_wdata;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;
endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: a 3-channel round-robin instance and a 2-channel fixed-priority instance.
module tb_mem_arbiter_n;
    localparam int unsigned AW = 16;
    localparam int unsigned BW = 128;
    localparam int unsigned NA = 3;
    localparam int unsigned NB = 2;

    logic clk;
    logic rst_na, rst_nb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_n_if #(.NUM_CH(NA), .ADDR_W(AW), .BURST_W(BW)) ifa ();
    mem_arbiter_n_if #(.NUM_CH(NB), .ADDR_W(AW), .BURST_W(BW)) ifb ();

    mem_arbiter_n #(.NUM_CH(NA), .ADDR_W(AW), .BURST_W(BW), .RR_MODE(1)) dut_a (
        .clk(clk), .reset_n(rst_na), .bus(ifa.slave));
    mem_arbiter_n #(.NUM_CH(NB), .ADDR_W(AW), .BURST_W(BW), .RR_MODE(0)) dut_b (
        .clk(clk), .reset_n(rst_nb), .bus(ifb.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference arbitration: first requester at or after ptr (mod n) when rr, else lowest index.
    function automatic int unsigned pick(input int unsigned mask, input int unsigned n,
                                         input int unsigned ptr, input bit rr);
        for (int unsigned k = 0; k < n; k++) begin
            int unsigned c;
            c = rr ? ((ptr + k) % n) : k;
            if (mask[c]) return c;
        end
        return n;
    endfunction

    function automatic logic [BW-1:0] rand_burst();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Requester model for instance A.
    bit             want_a [NA];
    bit             rd_a   [NA];
    bit             wr_a   [NA];
    logic [AW-1:0]  addr_a [NA];
    logic [BW-1:0]  wd_a   [NA];
    int unsigned    ptr_a;

    task automatic new_req_a(input int unsigned c);
        int unsigned op;
        op        = $urandom_range(0, 2);
        want_a[c] = 1'b1;
        rd_a[c]   = (op != 1);
        wr_a[c]   = (op != 0);
        addr_a[c] = AW'($urandom());
        wd_a[c]   = rand_burst();
    endtask

    task automatic drive_a();
        for (int i = 0; i < NA; i++) begin
            ifa.req_read[i]             = want_a[i] & rd_a[i];
            ifa.req_write[i]            = want_a[i] & wr_a[i];
            ifa.req_address[i*AW +: AW] = addr_a[i];
            ifa.req_wdata[i*BW +: BW]   = wd_a[i];
        end
    endtask

    function automatic int unsigned mask_a();
        int unsigned m;
        m = 0;
        for (int i = 0; i < NA; i++) if (want_a[i]) m = m | (32'd1 << i);
        return m;
    endfunction

    // From an IDLE negedge with requests driven: grant, hold, respond, return to IDLE.
    task automatic serve_a(input int unsigned w, input int unsigned hold, input bit inject);
        logic [BW-1:0] rd;
        step();
        check_eq("a_grant_valid", BW'(ifa.grant_valid), BW'(1));
        check_eq("a_grant_id",    BW'(ifa.grant_id),    BW'(w));
        check_eq("a_l2_read",     BW'(ifa.l2_read),     BW'(rd_a[w] & ~wr_a[w]));
        check_eq("a_l2_write",    BW'(ifa.l2_write),    BW'(wr_a[w]));
        check_eq("a_l2_address",  BW'(ifa.l2_address),  BW'(addr_a[w]));
        check_eq("a_l2_wdata",    ifa.l2_wdata,         wd_a[w]);
        for (int unsigned h = 0; h < hold; h++) begin
            if (inject)
                for (int c = 0; c < NA; c++)
                    if (!want_a[c] && $urandom_range(0, 3) == 0) new_req_a(c);
            drive_a();
            step();
            check_eq("a_busy_resp", BW'(ifa.req_resp),   BW'(0));
            check_eq("a_busy_addr", BW'(ifa.l2_address), BW'(addr_a[w]));
            check_eq("a_busy_id",   BW'(ifa.grant_id),   BW'(w));
        end
        rd = rand_burst();
        ifa.l2_rdata = rd;
        ifa.l2_resp  = 1'b1;
        #1;
        check_eq("a_req_resp",  BW'(ifa.req_resp), BW'(32'd1 << w));
        check_eq("a_req_rdata", ifa.req_rdata,     rd);
        step();
        ifa.l2_resp = 1'b0;
        check_eq("a_done_read",  BW'(ifa.l2_read),     BW'(0));
        check_eq("a_done_write", BW'(ifa.l2_write),    BW'(0));
        check_eq("a_done_valid", BW'(ifa.grant_valid), BW'(0));
        check_eq("a_idle_rdata", ifa.req_rdata,        BW'(0));
        want_a[w] = 1'b0;
        ptr_a     = (w + 1) % NA;
        drive_a();
    endtask

    // B-side single completion at the current negedge.
    task automatic resp_b(input int unsigned w);
        logic [BW-1:0] rd;
        rd = rand_burst();
        ifb.l2_rdata = rd;
        ifb.l2_resp  = 1'b1;
        #1;
        check_eq("b_req_resp",  BW'(ifb.req_resp), BW'(32'd1 << w));
        check_eq("b_req_rdata", ifb.req_rdata,     rd);
        step();
        ifb.l2_resp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned m;
        rst_na = 1'b0;
        rst_nb = 1'b0;
        ifa.req_read = '0; ifa.req_write = '0; ifa.req_address = '0; ifa.req_wdata = '0;
        ifa.l2_resp = 1'b0; ifa.l2_rdata = '0;
        ifb.req_read = '0; ifb.req_write = '0; ifb.req_address = '0; ifb.req_wdata = '0;
        ifb.l2_resp = 1'b0; ifb.l2_rdata = '0;
        for (int i = 0; i < NA; i++) begin
            want_a[i] = 1'b0; rd_a[i] = 1'b0; wr_a[i] = 1'b0; addr_a[i] = '0; wd_a[i] = '0;
        end
        ptr_a = 0;
        step();
        step();
        check_eq("rst_a_read",  BW'(ifa.l2_read),     BW'(0));
        check_eq("rst_a_valid", BW'(ifa.grant_valid), BW'(0));
        check_eq("rst_a_addr",  BW'(ifa.l2_address),  BW'(0));
        check_eq("rst_b_write", BW'(ifb.l2_write),    BW'(0));
        check_eq("rst_b_id",    BW'(ifb.grant_id),    BW'(0));
        check_eq("rst_b_wdata", ifb.l2_wdata,         BW'(0));
        rst_na = 1'b1;
        rst_nb = 1'b1;
        step();

        // Single read on channel 1, response in cycle 4.
        ifb.req_read    = 2'b10;
        ifb.req_address = {16'h1234, 16'h0000};
        step();
        check_eq("b_rd_l2_read", BW'(ifb.l2_read),    BW'(1));
        check_eq("b_rd_l2_addr", BW'(ifb.l2_address), BW'(16'h1234));
        check_eq("b_rd_id",      BW'(ifb.grant_id),   BW'(1));
        step();
        step();
        step();
        ifb.l2_rdata = BW'(128'hBEEF);
        ifb.l2_resp  = 1'b1;
        #1;
        check_eq("b_rd_resp",  BW'(ifb.req_resp), BW'(2'b10));
        check_eq("b_rd_rdata", ifb.req_rdata,     BW'(128'hBEEF));
        step();
        ifb.l2_resp  = 1'b0;
        ifb.req_read = 2'b00;
        check_eq("b_rd_drop", BW'(ifb.l2_read), BW'(0));

        // Stray response while idle.
        ifb.l2_resp = 1'b1;
        #1;
        check_eq("b_stray_resp", BW'(ifb.req_resp), BW'(0));
        step();
        ifb.l2_resp = 1'b0;
        check_eq("b_stray_valid", BW'(ifb.grant_valid), BW'(0));

        // Write with read also set; wdata change during BUSY must not propagate.
        ifb.req_write            = 2'b01;
        ifb.req_read             = 2'b01;
        ifb.req_wdata[BW-1:0]    = BW'(128'hA5A5);
        ifb.req_address[AW-1:0]  = AW'(16'h0042);
        step();
        check_eq("b_wr_write", BW'(ifb.l2_write), BW'(1));
        check_eq("b_wr_read",  BW'(ifb.l2_read),  BW'(0));
        check_eq("b_wr_wdata", ifb.l2_wdata,      BW'(128'hA5A5));
        ifb.req_wdata[BW-1:0] = BW'(128'h5A5A);
        step();
        check_eq("b_wr_hold", ifb.l2_wdata, BW'(128'hA5A5));
        resp_b(0);
        ifb.req_write = 2'b00;
        ifb.req_read  = 2'b00;
        check_eq("b_wr_drop", BW'(ifb.l2_write), BW'(0));

        // Fixed priority: channel 0 keeps re-requesting, channel 1 starves.
        ifb.req_read    = 2'b11;
        ifb.req_address = {16'h0200, 16'h0100};
        for (int t = 0; t < 4; t++) begin
            step();
            check_eq("b_fp_id",   BW'(ifb.grant_id),   BW'(0));
            check_eq("b_fp_addr", BW'(ifb.l2_address), BW'(16'h0100));
            resp_b(0);
        end
        ifb.req_read = 2'b10;
        step();
        check_eq("b_fp_id1",   BW'(ifb.grant_id),   BW'(1));
        check_eq("b_fp_addr1", BW'(ifb.l2_address), BW'(16'h0200));
        resp_b(1);
        ifb.req_read = 2'b00;

        // Round-robin contention: order 0,1,2, and a re-request of 0 waits for 1 and 2.
        for (int c = 0; c < NA; c++) new_req_a(c);
        drive_a();
        serve_a(0, 1, 1'b0);
        new_req_a(0);
        drive_a();
        serve_a(1, 0, 1'b0);
        serve_a(2, 2, 1'b0);
        serve_a(0, 0, 1'b0);

        // Reset two cycles into a grant while the pointer is nonzero.
        new_req_a(1);
        rd_a[1] = 1'b1;
        wr_a[1] = 1'b0;
        drive_a();
        step();
        check_eq("a_rst_pre_id",   BW'(ifa.grant_id), BW'(1));
        check_eq("a_rst_pre_read", BW'(ifa.l2_read),  BW'(1));
        step();
        step();
        new_req_a(0);
        drive_a();
        ifa.l2_resp = 1'b1;
        rst_na      = 1'b0;
        #1;
        check_eq("a_rst_read",  BW'(ifa.l2_read),     BW'(0));
        check_eq("a_rst_write", BW'(ifa.l2_write),    BW'(0));
        check_eq("a_rst_valid", BW'(ifa.grant_valid), BW'(0));
        check_eq("a_rst_resp",  BW'(ifa.req_resp),    BW'(0));
        step();
        ifa.l2_resp = 1'b0;
        rst_na      = 1'b1;
        ptr_a       = 0;
        serve_a(0, 1, 1'b0);
        serve_a(1, 0, 1'b0);

        // Randomised traffic against the reference arbitration.
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NA; c++)
                if (!want_a[c] && $urandom_range(0, 1) == 1) new_req_a(c);
            drive_a();
            m = mask_a();
            if (m == 0) begin
                ifa.l2_rdata = rand_burst();
                ifa.l2_resp  = 1'($urandom_range(0, 1));
                #1;
                check_eq("a_idle_resp",  BW'(ifa.req_resp), BW'(0));
                check_eq("a_idle_rdata", ifa.req_rdata,     BW'(0));
                step();
                ifa.l2_resp = 1'b0;
                check_eq("a_idle_valid", BW'(ifa.grant_valid), BW'(0));
                check_eq("a_idle_read",  BW'(ifa.l2_read),     BW'(0));
            end else begin
                serve_a(pick(m, NA, ptr_a, 1'b1), $urandom_range(0, 3), 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
